// File: rtl/rbus_pkg.sv
// Shared types for the ring switch-box word bus and the buffered entry format.
package rbus_pkg;

    typedef struct packed {
        logic [7:0]  hdr;
        logic [23:0] data;
    } rbus_word_t;

    typedef struct packed {
        logic       sof;
        logic       eof;
        rbus_word_t bus;
    } rbus_ent_t;

endpackage

// File: rtl/rsbus_branch_r2d_rx.sv
// Store-and-forward receive buffer for the slice switch-box r2d branch: staging word, FIFO, credit readiness.
// Optional frame protocol checker compiled in with RSBUS_R2D_RX_FRAME_CHECK_EN.
module rsbus_branch_r2d_rx
    import rbus_pkg::*;
#(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned FRAME_MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_stb,
    input  logic       i_sof,
    input  rbus_word_t i_bus,
    output logic [1:0] i_rdy,
    output logic       o_vld,
    output logic       o_sof,
    output logic       o_eof,
    output rbus_word_t o_bus,
    input  logic       o_rd,
    output logic       ff_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic {ST_PASS, ST_DROP} state_t;

    state_t           state_q, state_d;
    logic             stage_vld_q;
    logic             stage_sof_q;
    rbus_word_t       stage_bus_q;
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW-1:0]    fcnt_q, fcnt_d;
    logic [1:0]       rdy_q, rdy_d;
    logic             err_q;
    rbus_ent_t        mem_q [DEPTH];

    logic             eof_c, full, pop, wr_en, ovf_err, chk_err;
    logic [PW-1:0]    used;
    logic [CW-1:0]    occ;
    rbus_ent_t        head, wr_ent;

    // A staged word closes its frame when the next cycle is idle or starts a new frame.
    assign eof_c  = !i_stb || i_sof;
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head   = mem_q[rptr_q[AW-1:0]];
    assign o_vld  = (fcnt_q != '0);
    assign pop    = o_rd && o_vld;
    assign used   = wptr_q - rptr_q;
    assign occ    = CW'(used) + CW'(stage_vld_q);

    assign wr_ent.sof = stage_sof_q;
    assign wr_ent.eof = eof_c;
    assign wr_ent.bus = stage_bus_q;

    assign o_sof  = o_vld && head.sof;
    assign o_eof  = o_vld && head.eof;
    assign o_bus  = o_vld ? head.bus : '0;
    assign i_rdy  = rdy_q;
    assign ff_err = err_q;

    // Write / drop decision for the staged word; a full FIFO with a same-cycle pop still accepts.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        ovf_err = 1'b0;
        if (stage_vld_q) begin
            if (state_q == ST_DROP && !stage_sof_q) begin
                state_d = eof_c ? ST_PASS : ST_DROP;
            end else if (full && !pop) begin
                state_d = eof_c ? ST_PASS : ST_DROP;
                ovf_err = 1'b1;
            end else begin
                wr_en   = 1'b1;
                state_d = ST_PASS;
            end
        end
    end

    always_comb begin
        wptr_d = wptr_q + PW'(wr_en);
        rptr_d = rptr_q + PW'(pop);
        fcnt_d = fcnt_q + PW'(wr_en && eof_c) - PW'(pop && head.eof);
        rdy_d  = {occ <= CW'(DEPTH - 2 * FRAME_MAX), occ <= CW'(DEPTH - FRAME_MAX)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_PASS;
            stage_vld_q <= 1'b0;
            stage_sof_q <= 1'b0;
            stage_bus_q <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fcnt_q      <= '0;
            rdy_q       <= 2'b00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_vld_q <= i_stb;
            if (i_stb) begin
                stage_sof_q <= i_sof;
                stage_bus_q <= i_bus;
            end
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fcnt_q      <= fcnt_d;
            rdy_q       <= rdy_d;
            err_q       <= err_q || ovf_err || chk_err;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= wr_ent;
        end
    end

`ifdef RSBUS_R2D_RX_FRAME_CHECK_EN
    localparam int unsigned LW = $clog2(FRAME_MAX + 2);

    logic          prev_stb_q;
    logic [LW-1:0] len_q, len_d;

    // Input-side frame checker: missing sof after idle, or length beyond FRAME_MAX (saturating count).
    always_comb begin
        len_d   = len_q;
        chk_err = 1'b0;
        if (i_stb) begin
            if (i_sof || !prev_stb_q) begin
                len_d = LW'(1);
            end else if (len_q <= LW'(FRAME_MAX)) begin
                len_d = len_q + LW'(1);
            end
            chk_err = (!i_sof && !prev_stb_q) || (len_d > LW'(FRAME_MAX));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_stb_q <= 1'b0;
            len_q      <= '0;
        end else begin
            prev_stb_q <= i_stb;
            len_q      <= len_d;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_rsbus_branch_r2d_rx.sv
// Scoreboard bench for rsbus_branch_r2d_rx: stored words queued when driven, compared when popped.
module tb_rsbus_branch_r2d_rx;
    import rbus_pkg::*;

    localparam int unsigned DEPTH     = 32;
    localparam int unsigned FRAME_MAX = 9;
`ifdef RSBUS_R2D_RX_FRAME_CHECK_EN
    localparam logic CHK_ERR = 1'b1;
`else
    localparam logic CHK_ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       i_stb;
    logic       i_sof;
    rbus_word_t i_bus;
    logic [1:0] i_rdy;
    logic       o_vld;
    logic       o_sof;
    logic       o_eof;
    rbus_word_t o_bus;
    logic       o_rd;
    logic       ff_err;

    rbus_ent_t  sb_q [$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    rsbus_branch_r2d_rx #(.DEPTH(DEPTH), .FRAME_MAX(FRAME_MAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_stb  (i_stb),
        .i_sof  (i_sof),
        .i_bus  (i_bus),
        .i_rdy  (i_rdy),
        .o_vld  (o_vld),
        .o_sof  (o_sof),
        .o_eof  (o_eof),
        .o_bus  (o_bus),
        .o_rd   (o_rd),
        .ff_err (ff_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        i_stb = 1'b0;
        i_sof = 1'b0;
        repeat (n) tick();
    endtask

    // Drives len words; leaves i_stb high so a following call forms a back-to-back frame.
    task automatic send_frame(input int len, input bit with_sof, input logic [31:0] base, input bit store);
        rbus_ent_t e;
        for (int i = 0; i < len; i++) begin
            i_stb = 1'b1;
            i_sof = with_sof && (i == 0);
            i_bus = rbus_word_t'(base + 32'(i));
            if (store) begin
                e.sof = with_sof && (i == 0);
                e.eof = (i == len - 1);
                e.bus = rbus_word_t'(base + 32'(i));
                sb_q.push_back(e);
            end
            tick();
        end
    endtask

    task automatic pop_one(input string tag);
        int        waited = 0;
        rbus_ent_t e;
        while (!o_vld && waited < 20) begin
            tick();
            waited++;
        end
        if (!o_vld) begin
            check({tag, "_vld_timeout"}, 64'(o_vld), 64'(1));
            return;
        end
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'(1));
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_head"}, 64'({o_sof, o_eof, o_bus}), 64'(e));
        o_rd = 1'b1;
        tick();
        o_rd = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) pop_one(tag);
    endtask

    initial begin
        rbus_ent_t e;
        rst   = 1'b0;
        i_stb = 1'b0;
        i_sof = 1'b0;
        i_bus = '0;
        o_rd  = 1'b0;
        #2;
        check("rst_vld",  64'(o_vld),  64'(0));
        check("rst_sof",  64'(o_sof),  64'(0));
        check("rst_eof",  64'(o_eof),  64'(0));
        check("rst_bus",  64'(o_bus),  64'(0));
        check("rst_rdy",  64'(i_rdy),  64'(0));
        check("rst_err",  64'(ff_err), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        check("rel_rdy_hold", 64'(i_rdy), 64'(0));
        tick();
        check("rel_rdy_first", 64'(i_rdy), 64'(3));

        // Single 3-word frame: o_vld appears the cycle after the stage word is committed.
        send_frame(3, 1'b1, 32'h0100_0000, 1'b1);
        check("f3_vld_early", 64'(o_vld), 64'(0));
        idle(1);
        check("f3_vld", 64'(o_vld), 64'(1));
        drain(3, "f3");
        check("f3_vld_empty", 64'(o_vld), 64'(0));

        // Back-to-back 2 + 4 word frames.
        send_frame(2, 1'b1, 32'h0200_0000, 1'b1);
        send_frame(4, 1'b1, 32'h0300_0000, 1'b1);
        idle(2);
        drain(2, "b2b_a");
        check("b2b_second_ready", 64'(o_vld), 64'(1));
        drain(4, "b2b_b");
        check("b2b_empty", 64'(o_vld), 64'(0));

        // Credit thresholds at 24 words.
        idle(2);
        check("cr_empty", 64'(i_rdy), 64'(3));
        send_frame(8, 1'b1, 32'h0400_0000, 1'b1);
        send_frame(8, 1'b1, 32'h0410_0000, 1'b1);
        send_frame(8, 1'b1, 32'h0420_0000, 1'b1);
        check("cr_one", 64'(i_rdy), 64'(1));
        idle(1);
        check("cr_none", 64'(i_rdy), 64'(0));
        drain(15, "cr_pop");
        idle(2);
        check("cr_back", 64'(i_rdy), 64'(3));
        drain(9, "cr_rest");

        // Fill to 32, pass-through write+pop at full, then overflow of a whole frame.
        for (int f = 0; f < 4; f++) send_frame(8, 1'b1, 32'h0500_0000 + 32'(f << 8), 1'b1);
        idle(2);
        check("ovf_full_rdy", 64'(i_rdy), 64'(0));
        i_stb = 1'b1;
        i_sof = 1'b1;
        i_bus = rbus_word_t'(32'h0600_00AA);
        e.sof = 1'b1;
        e.eof = 1'b1;
        e.bus = rbus_word_t'(32'h0600_00AA);
        sb_q.push_back(e);
        tick();
        i_stb = 1'b0;
        i_sof = 1'b0;
        pop_one("pt");
        idle(1);
        check("pt_no_err", 64'(ff_err), 64'(0));
        send_frame(3, 1'b1, 32'h0700_0000, 1'b0);
        idle(2);
        check("ovf_err", 64'(ff_err), 64'(1));
        drain(32, "ovf");
        check("ovf_drained", 64'(o_vld), 64'(0));
        send_frame(2, 1'b1, 32'h0800_0000, 1'b1);
        idle(2);
        drain(2, "post_ovf");
        check("ovf_sticky", 64'(ff_err), 64'(1));

        // Reset asserted mid-frame with a complete frame already stored.
        send_frame(2, 1'b1, 32'h0900_0000, 1'b0);
        idle(2);
        check("mr_pre_vld", 64'(o_vld), 64'(1));
        send_frame(2, 1'b1, 32'h0A00_0000, 1'b0);
        rst = 1'b0;
        #1;
        check("mr_vld", 64'(o_vld),  64'(0));
        check("mr_sof", 64'(o_sof),  64'(0));
        check("mr_eof", 64'(o_eof),  64'(0));
        check("mr_bus", 64'(o_bus),  64'(0));
        check("mr_rdy", 64'(i_rdy),  64'(0));
        check("mr_err", 64'(ff_err), 64'(0));
        i_stb = 1'b0;
        i_sof = 1'b0;
        tick();
        rst = 1'b1;
        idle(2);
        check("mr_after_vld", 64'(o_vld), 64'(0));
        check("mr_after_rdy", 64'(i_rdy), 64'(3));

        // Frame without sof after idle, then an over-length frame: both stored.
        send_frame(3, 1'b0, 32'h0B00_0000, 1'b1);
        idle(2);
        check("nosof_err", 64'(ff_err), 64'(CHK_ERR));
        check("nosof_vld", 64'(o_vld), 64'(1));
        drain(3, "nosof");
        send_frame(10, 1'b1, 32'h0C00_0000, 1'b1);
        idle(2);
        drain(10, "long");
        check("long_err", 64'(ff_err), 64'(CHK_ERR));
        check("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
